// File: rtl/load_align_unit_if.sv
// Load-align bus: request, memory response beats and load result.
// master drives req/mem/load_ready; slave is the align unit.
interface load_align_unit_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_BITS   = 20,
   parameter int LOG2_NUM_BYTES = $clog2(DATA_WIDTH / 8)
);
   logic                      req_valid;
   logic                      req_ready;
   logic [LOG2_NUM_BYTES-1:0] req_log2_bytes;
   logic                      req_unsigned;
   logic [ADDRESS_BITS-1:0]   req_address;
   logic                      mem_valid;
   logic [DATA_WIDTH-1:0]     mem_data;
   logic                      load_valid;
   logic                      load_ready;
   logic [DATA_WIDTH-1:0]     load_data;
   logic                      load_split;
   logic                      load_error;

   modport master (
      output req_valid, req_log2_bytes, req_unsigned, req_address,
      output mem_valid, mem_data, load_ready,
      input  req_ready, load_valid, load_data, load_split, load_error
   );

   modport slave (
      input  req_valid, req_log2_bytes, req_unsigned, req_address,
      input  mem_valid, mem_data, load_ready,
      output req_ready, load_valid, load_data, load_split, load_error
   );
endinterface

// File: rtl/load_align_unit.sv
// Load align unit: merges one or two word-aligned memory beats into an
// aligned, sign/zero-extended load result.
// Ports: clock, reset (sync, active high), bus (slave modport of
// load_align_unit_if: req_*, mem_*, load_*), protocol_error (sticky).
module load_align_unit #(
   parameter int CORE           = 0,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_BITS   = 20,
   parameter int NUM_BYTES      = DATA_WIDTH / 8,
   parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES)
) (
   input  logic               clock,
   input  logic               reset,
   load_align_unit_if.slave   bus,
   output logic               protocol_error
);

   if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || CORE < 0) begin : g_bad_param
      $error("load_align_unit: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LO,
      WAIT_HI,
      DONE
   } state_t;

   state_t                    state;
   logic [LOG2_NUM_BYTES-1:0] size_q;
   logic [LOG2_NUM_BYTES-1:0] off_q;
   logic                      uns_q;
   logic                      split_q;
   logic                      err_q;
   logic [DATA_WIDTH-1:0]     lo_q;

   // Only the byte offset matters; upper address bits are don't-care.
   logic                      unused_addr;
   logic [LOG2_NUM_BYTES-1:0] req_off;
   logic                      req_err;
   logic                      req_split;

   assign unused_addr = ^bus.req_address;
   assign req_off     = bus.req_address[LOG2_NUM_BYTES-1:0];
   assign req_err     = int'(bus.req_log2_bytes) > LOG2_NUM_BYTES;
   assign req_split   = !req_err &&
                        ((int'(req_off) + (1 << int'(bus.req_log2_bytes)))
                         > NUM_BYTES);

   // The beat arriving now is combined with the stored low beat (if any)
   // so the result can be registered on the same edge as the final beat.
   logic [DATA_WIDTH-1:0]   beat_lo;
   logic [DATA_WIDTH-1:0]   beat_hi;
   logic [2*DATA_WIDTH-1:0] wide;
   logic [DATA_WIDTH-1:0]   shifted;
   logic [DATA_WIDTH-1:0]   result;
   logic                    sign;
   logic [7:0]              fill;

   always_comb begin
      beat_lo = bus.mem_data;
      beat_hi = '0;
      if (state == WAIT_HI) begin
         beat_lo = lo_q;
         beat_hi = bus.mem_data;
      end
   end

   assign wide    = {beat_hi, beat_lo} >> {off_q, 3'b000};
   assign shifted = wide[DATA_WIDTH-1:0];

   always_comb begin
      sign   = 1'b0;
      result = '0;
      for (int k = 0; k <= LOG2_NUM_BYTES; k++) begin
         if (int'(size_q) == k) sign = shifted[8*(1<<k)-1];
      end
      fill = (sign && !uns_q) ? 8'hFF : 8'h00;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (b < (1 << int'(size_q)))
            result[8*b +: 8] = shifted[8*b +: 8];
         else
            result[8*b +: 8] = fill;
      end
      if (err_q) result = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         bus.req_ready  <= 1'b1;
         bus.load_valid <= 1'b0;
         bus.load_data  <= '0;
         bus.load_split <= 1'b0;
         bus.load_error <= 1'b0;
         protocol_error <= 1'b0;
         size_q         <= '0;
         off_q          <= '0;
         uns_q          <= 1'b0;
         split_q        <= 1'b0;
         err_q          <= 1'b0;
         lo_q           <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  size_q        <= bus.req_log2_bytes;
                  off_q         <= req_off;
                  uns_q         <= bus.req_unsigned;
                  split_q       <= req_split;
                  err_q         <= req_err;
                  bus.req_ready <= 1'b0;
                  state         <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (bus.mem_valid) begin
                  lo_q <= bus.mem_data;
                  if (split_q) begin
                     state <= WAIT_HI;
                  end else begin
                     state          <= DONE;
                     bus.load_valid <= 1'b1;
                     bus.load_data  <= result;
                     bus.load_split <= 1'b0;
                     bus.load_error <= err_q;
                  end
               end
            end
            WAIT_HI: begin
               if (bus.mem_valid) begin
                  state          <= DONE;
                  bus.load_valid <= 1'b1;
                  bus.load_data  <= result;
                  bus.load_split <= 1'b1;
                  bus.load_error <= 1'b0;
               end
            end
            DONE: begin
               if (bus.load_ready) begin
                  state          <= IDLE;
                  bus.load_valid <= 1'b0;
                  bus.req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (bus.mem_valid && (state == IDLE || state == DONE))
            protocol_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 32-bit vector table plus
// hand sequences for stall, reset abort and the 64-bit instance.
module tb_load_align_unit;

   logic clk = 1'b0;
   logic reset;
   logic perr32;
   logic perr64;

   always #5 clk = ~clk;

   load_align_unit_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20),
                        .LOG2_NUM_BYTES(2)) i32 ();
   load_align_unit_if #(.DATA_WIDTH(64), .ADDRESS_BITS(20),
                        .LOG2_NUM_BYTES(3)) i64 ();

   load_align_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20))
      u32 (.clock(clk), .reset(reset), .bus(i32), .protocol_error(perr32));

   load_align_unit #(.CORE(1), .DATA_WIDTH(64), .ADDRESS_BITS(20))
      u64 (.clock(clk), .reset(reset), .bus(i64), .protocol_error(perr64));

   typedef struct {
      logic [1:0]  size;
      logic        uns;
      logic [19:0] addr;
      logic [31:0] b0;
      logic [31:0] b1;
      logic [31:0] exp;
      logic        split;
      logic        err;
   } vec_t;

   vec_t vecs [15];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic do32(input vec_t v, input string tag);
      i32.req_valid      = 1'b1;
      i32.req_log2_bytes = v.size;
      i32.req_unsigned   = v.uns;
      i32.req_address    = v.addr;
      tick();
      i32.req_valid = 1'b0;
      check({tag, ".busy"}, {63'd0, i32.req_ready}, 64'd0);
      i32.mem_valid = 1'b1;
      i32.mem_data  = v.b0;
      tick();
      if (v.split) begin
         check({tag, ".hi_wait"}, {63'd0, i32.load_valid}, 64'd0);
         i32.mem_data = v.b1;
         tick();
      end
      i32.mem_valid = 1'b0;
      check({tag, ".valid"}, {63'd0, i32.load_valid}, 64'd1);
      check({tag, ".data"}, {32'd0, i32.load_data}, {32'd0, v.exp});
      check({tag, ".split"}, {63'd0, i32.load_split}, {63'd0, v.split});
      check({tag, ".err"}, {63'd0, i32.load_error}, {63'd0, v.err});
      i32.load_ready = 1'b1;
      tick();
      i32.load_ready = 1'b0;
      check({tag, ".drop"}, {63'd0, i32.load_valid}, 64'd0);
      check({tag, ".ready"}, {63'd0, i32.req_ready}, 64'd1);
      check({tag, ".perr"}, {63'd0, perr32}, 64'd0);
   endtask

   task automatic do64(input logic [2:0] size, input logic uns,
                       input logic [19:0] addr, input logic [63:0] b0,
                       input logic [63:0] b1, input logic split,
                       input logic [63:0] exp, input logic err,
                       input string tag);
      i64.req_valid      = 1'b1;
      i64.req_log2_bytes = size;
      i64.req_unsigned   = uns;
      i64.req_address    = addr;
      tick();
      i64.req_valid = 1'b0;
      i64.mem_valid = 1'b1;
      i64.mem_data  = b0;
      tick();
      if (split) begin
         i64.mem_data = b1;
         tick();
      end
      i64.mem_valid = 1'b0;
      check({tag, ".valid"}, {63'd0, i64.load_valid}, 64'd1);
      check({tag, ".data"}, i64.load_data, exp);
      check({tag, ".split"}, {63'd0, i64.load_split}, {63'd0, split});
      check({tag, ".err"}, {63'd0, i64.load_error}, {63'd0, err});
      i64.load_ready = 1'b1;
      tick();
      i64.load_ready = 1'b0;
      check({tag, ".ready"}, {63'd0, i64.req_ready}, 64'd1);
      check({tag, ".perr"}, {63'd0, perr64}, 64'd0);
   endtask

   initial begin
      vec_t v;

      vecs[0]  = '{2'd0, 1'b0, 20'h00003, 32'h80AABBCC, 32'h0,
                   32'hFFFFFF80, 1'b0, 1'b0};
      vecs[1]  = '{2'd1, 1'b1, 20'h00003, 32'h11223344, 32'h55667788,
                   32'h00008811, 1'b1, 1'b0};
      vecs[2]  = '{2'd1, 1'b0, 20'h00003, 32'h11223344, 32'h55667788,
                   32'hFFFF8811, 1'b1, 1'b0};
      vecs[3]  = '{2'd2, 1'b0, 20'h00000, 32'hDEADBEEF, 32'h0,
                   32'hDEADBEEF, 1'b0, 1'b0};
      vecs[4]  = '{2'd2, 1'b1, 20'h00001, 32'h44332211, 32'h88776655,
                   32'h55443322, 1'b1, 1'b0};
      vecs[5]  = '{2'd0, 1'b1, 20'h00002, 32'h12F45678, 32'h0,
                   32'h000000F4, 1'b0, 1'b0};
      vecs[6]  = '{2'd0, 1'b0, 20'h00002, 32'h12F45678, 32'h0,
                   32'hFFFFFFF4, 1'b0, 1'b0};
      vecs[7]  = '{2'd1, 1'b0, 20'h00002, 32'h7FFF0000, 32'h0,
                   32'h00007FFF, 1'b0, 1'b0};
      vecs[8]  = '{2'd1, 1'b0, 20'h12345, 32'hAA8001BB, 32'h0,
                   32'hFFFF8001, 1'b0, 1'b0};
      vecs[9]  = '{2'd3, 1'b0, 20'h00000, 32'hFFFFFFFF, 32'h0,
                   32'h00000000, 1'b0, 1'b1};
      vecs[10] = '{2'd3, 1'b1, 20'h00003, 32'hFFFFFFFF, 32'h0,
                   32'h00000000, 1'b0, 1'b1};
      vecs[11] = '{2'd2, 1'b0, 20'h00002, 32'hCCDD0000, 32'h0000AABB,
                   32'hAABBCCDD, 1'b1, 1'b0};
      vecs[12] = '{2'd2, 1'b1, 20'h00002, 32'hCCDD0000, 32'h0000AABB,
                   32'hAABBCCDD, 1'b1, 1'b0};
      vecs[13] = '{2'd0, 1'b1, 20'hFFFFF, 32'hA5000000, 32'h0,
                   32'h000000A5, 1'b0, 1'b0};
      vecs[14] = '{2'd1, 1'b1, 20'h00001, 32'h00ABCD00, 32'h0,
                   32'h0000ABCD, 1'b0, 1'b0};

      reset = 1'b1;
      i32.req_valid = 1'b0; i32.req_log2_bytes = '0;
      i32.req_unsigned = 1'b0; i32.req_address = '0;
      i32.mem_valid = 1'b0; i32.mem_data = '0; i32.load_ready = 1'b0;
      i64.req_valid = 1'b0; i64.req_log2_bytes = '0;
      i64.req_unsigned = 1'b0; i64.req_address = '0;
      i64.mem_valid = 1'b0; i64.mem_data = '0; i64.load_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check("rst.ready", {63'd0, i32.req_ready}, 64'd1);
      check("rst.valid", {63'd0, i32.load_valid}, 64'd0);
      check("rst.data", {32'd0, i32.load_data}, 64'd0);
      check("rst.split", {63'd0, i32.load_split}, 64'd0);
      check("rst.err", {63'd0, i32.load_error}, 64'd0);
      check("rst.perr", {63'd0, perr32}, 64'd0);

      // stray beat in IDLE
      i32.mem_valid = 1'b1;
      i32.mem_data  = 32'h12345678;
      tick();
      i32.mem_valid = 1'b0;
      check("idle_beat.perr", {63'd0, perr32}, 64'd1);
      check("idle_beat.valid", {63'd0, i32.load_valid}, 64'd0);
      check("idle_beat.ready", {63'd0, i32.req_ready}, 64'd1);
      do_reset();
      check("idle_beat.clr", {63'd0, perr32}, 64'd0);

      for (int i = 0; i < 15; i++) begin
         do32(vecs[i], $sformatf("vec%0d", i));
      end

      // stall in DONE with a stray beat
      i32.req_valid = 1'b1; i32.req_log2_bytes = 2'd2;
      i32.req_unsigned = 1'b0; i32.req_address = 20'h0;
      tick();
      i32.req_valid = 1'b0;
      i32.mem_valid = 1'b1; i32.mem_data = 32'h12345678;
      tick();
      i32.mem_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d.valid", c), {63'd0, i32.load_valid}, 64'd1);
         check($sformatf("stall%0d.data", c), {32'd0, i32.load_data},
               64'h12345678);
         if (c == 2) begin
            i32.mem_valid = 1'b1;
            i32.mem_data  = 32'hCAFEF00D;
         end
         tick();
         i32.mem_valid = 1'b0;
      end
      check("stall.perr", {63'd0, perr32}, 64'd1);
      check("stall.hold", {32'd0, i32.load_data}, 64'h12345678);
      check("stall.ready", {63'd0, i32.req_ready}, 64'd0);
      i32.load_ready = 1'b1;
      tick();
      i32.load_ready = 1'b0;
      check("stall.exit", {63'd0, i32.load_valid}, 64'd0);
      check("stall.perr_sticky", {63'd0, perr32}, 64'd1);
      do_reset();

      // reset while waiting for the high beat, with a beat on that edge
      i32.req_valid = 1'b1; i32.req_log2_bytes = 2'd1;
      i32.req_unsigned = 1'b1; i32.req_address = 20'h3;
      tick();
      i32.req_valid = 1'b0;
      i32.mem_valid = 1'b1; i32.mem_data = 32'h11223344;
      tick();
      reset = 1'b1;
      i32.mem_data = 32'h55667788;
      tick();
      reset = 1'b0;
      i32.mem_valid = 1'b0;
      check("abort.ready", {63'd0, i32.req_ready}, 64'd1);
      check("abort.valid", {63'd0, i32.load_valid}, 64'd0);
      check("abort.perr", {63'd0, perr32}, 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("abort.quiet%0d", c), {63'd0, i32.load_valid}, 64'd0);
      end
      v = '{2'd2, 1'b0, 20'h00000, 32'hDEADBEEF, 32'h0,
            32'hDEADBEEF, 1'b0, 1'b0};
      do32(v, "after_abort");

      // reset wins over a simultaneous request
      reset = 1'b1;
      i32.req_valid = 1'b1; i32.req_address = 20'h0;
      tick();
      reset = 1'b0;
      i32.req_valid = 1'b0;
      check("rst_prio.ready", {63'd0, i32.req_ready}, 64'd1);

      // request held high while busy is ignored
      i32.req_valid = 1'b1; i32.req_log2_bytes = 2'd0;
      i32.req_unsigned = 1'b1; i32.req_address = 20'h0;
      tick();
      i32.req_log2_bytes = 2'd2; i32.req_address = 20'h3;
      i32.mem_valid = 1'b1; i32.mem_data = 32'h11223344;
      tick();
      i32.mem_valid = 1'b0;
      i32.req_valid = 1'b0;
      check("busy_req.valid", {63'd0, i32.load_valid}, 64'd1);
      check("busy_req.data", {32'd0, i32.load_data}, 64'h44);
      check("busy_req.split", {63'd0, i32.load_split}, 64'd0);
      i32.load_ready = 1'b1;
      tick();
      i32.load_ready = 1'b0;
      check("busy_req.ready", {63'd0, i32.req_ready}, 64'd1);

      // 64-bit instance
      do64(3'd2, 1'b1, 20'h6, 64'hF0E0D0C0B0A09080, 64'h0706050403020100,
           1'b1, 64'h000000000100F0E0, 1'b0, "w64_lwu");
      do64(3'd2, 1'b0, 20'h4, 64'h8000000000000000, 64'h0,
           1'b0, 64'hFFFFFFFF80000000, 1'b0, "w64_lw");
      do64(3'd3, 1'b0, 20'h0, 64'h0123456789ABCDEF, 64'h0,
           1'b0, 64'h0123456789ABCDEF, 1'b0, "w64_ld");
      do64(3'd4, 1'b0, 20'h5, 64'hFFFFFFFFFFFFFFFF, 64'h0,
           1'b0, 64'h0, 1'b1, "w64_bad");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter CORE, default 0, core index used for trace labelling only.
REQ-002 Parameter DATA_WIDTH, default 32, memory word and load result width; legal values are 32 and 64.
REQ-003 Parameter ADDRESS_BITS, default 20, width of the request address.
REQ-004 Parameter NUM_BYTES, default DATA_WIDTH/8, bytes per memory word.
REQ-005 Parameter LOG2_NUM_BYTES, default log2(NUM_BYTES), byte-offset width.
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  load request present.
REQ-009 req_ready  out  1  block can accept a request.
REQ-010 req_log2_bytes  in  LOG2_NUM_BYTES  access size as log2(bytes).
REQ-011 req_unsigned  in  1  1 selects zero-extension, 0 selects sign-extension.
REQ-012 req_address  in  ADDRESS_BITS  byte address of the load.
REQ-013 mem_valid  in  1  memory response beat present.
REQ-014 mem_data  in  DATA_WIDTH  response word; word-aligned.
REQ-015 load_valid  out  1  result available.
REQ-016 load_ready  in  1  consumer accepts the result.
REQ-017 load_data  out  DATA_WIDTH  aligned and extended result.
REQ-018 load_split  out  1  the current result was merged from two beats.
REQ-019 load_error  out  1  the current result carries an illegal size; load_data is zero.
REQ-020 protocol_error  out  1  sticky flag; set by an unexpected mem_valid.

Function
REQ-021 The FSM SHALL have four states: IDLE, WAIT_LO, WAIT_HI and DONE; req_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, req_valid=1 SHALL capture size, sign, offset=req_address[LOG2_NUM_BYTES-1:0] and split=(offset + 2^size > NUM_BYTES), then move to WAIT_LO.
REQ-023 A size of 2^size > NUM_BYTES (e.g. size 3 at DATA_WIDTH=32) SHALL be illegal; it is accepted and still consumes one beat, then produces load_data=0 with load_error=1 and split forced to 0.
REQ-024 In WAIT_LO, mem_valid SHALL capture mem_data as lo, then move to WAIT_HI if split, else to DONE.
REQ-025 In WAIT_HI, mem_valid SHALL capture mem_data as hi, then move to DONE.
REQ-026 The result SHALL be the low DATA_WIDTH bits of ({hi,lo} >> (offset*8)), truncated to 2^size bytes, then extended to DATA_WIDTH: zero-extended if unsigned, otherwise sign-extended from the top byte of the access.
REQ-027 When 2^size = NUM_BYTES, signed and unsigned results SHALL be identical.
REQ-028 load_data, load_split and load_error SHALL be registered and valid in DONE; the final beat in cycle N gives load_valid=1 in cycle N+1.
REQ-029 In DONE, load_valid SHALL stay 1 and all outputs SHALL stay stable until load_ready=1; that cycle returns the FSM to IDLE.
REQ-030 Throughput: at most one request SHALL be in flight; no new request is accepted in the cycle DONE exits.
REQ-031 mem_valid in IDLE or DONE SHALL be ignored for data and SHALL set protocol_error, which stays 1 until reset.
REQ-032 req_valid outside IDLE SHALL have no effect.
REQ-033 Address bits above LOG2_NUM_BYTES SHALL be ignored; the block issues no memory requests.

Reset
REQ-034 While reset=1 at a clock edge: the FSM goes to IDLE; load_valid, load_data, load_split, load_error and protocol_error go to 0; req_ready=1 in the following cycle.
REQ-035 Reset during WAIT_LO, WAIT_HI or DONE SHALL discard the in-flight load with no result emitted.
REQ-036 Reset has priority over every simultaneous req_valid or mem_valid.

Verification
REQ-037 DATA_WIDTH=32, signed byte load (LB) at address 0x3, mem_data=0x80AABBCC -> next cycle load_data=0xFFFFFF80, load_split=0.
REQ-038 DATA_WIDTH=32, unsigned halfword load (LHU) at address 0x3, beats 0x11223344 then 0x55667788 -> load_data=0x00008811, load_split=1, load_valid one cycle after the second beat.
REQ-039 DATA_WIDTH=64, unsigned word load (LWU) at address 0x6, beats 0xF0E0D0C0B0A09080 then 0x0706050403020100 -> load_data=0x000000000100F0E0, load_split=1.
REQ-040 DATA_WIDTH=32, size=3, one beat -> load_data=0, load_error=1, load_split=0.
REQ-041 Hold load_ready=0 for 5 cycles in DONE -> load_valid and load_data stay stable; mem_valid during the stall sets protocol_error=1.
REQ-042 Assert reset in WAIT_HI -> next cycle IDLE and req_ready=1; no load_valid pulse; a following aligned load (LW) with beat 0xDEADBEEF returns 0xDEADBEEF.
